imem_loader: RTL

//  Writer side of the CPU instruction-memory interface: receives a framed byte stream
//  (boot/debug link), assembles 19-bit instruction words, writes them into imem and

---
 rtl/imem_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the CPU instruction-memory interface.
// Accepts a framed byte stream (SYNC, CNT_HI, CNT_LO, N x {B0,B1,B2}, CHK),
// assembles 19-bit words {B0[2:0],B1,B2}, writes them to imem and releases
// the core from reset only after the whole frame has been checksum-verified.
//
// Ports
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_in_valid    byte-stream valid
//   i_in_data     byte-stream data
//   o_in_ready    byte accepted when i_in_valid & o_in_ready
//   i_reload      1-cycle pulse, leaves DONE/ERR back to IDLE
//   o_imem_we     imem write enable, one pulse per word
//   o_imem_addr   imem write address
//   o_imem_wdata  imem write data
//   o_cpu_run     1 = core released from reset
//   o_done        program loaded and verified
//   o_err         frame rejected
//
// state   | meaning
// IDLE    | hunting for SYNC_BYTE, other bytes discarded
// CNT_HI  | expecting word-count high byte
// CNT_LO  | expecting word-count low byte, range-checked
// W0      | expecting B0 (upper 5 bits must be zero)
// W1      | expecting B1
// W2      | expecting B2
// WRITE   | one-cycle imem write of the assembled word
// CHK     | expecting XOR checksum of all word bytes
// DONE    | verified, core running; waits for reload
// ERR     | rejected, core held; waits for reload

module imem_loader #(
    parameter int          DATA_W    = 19,
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    input  logic              i_reload,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [DATA_W-1:0] o_imem_wdata,
    output logic              o_cpu_run,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_W0, S_W1, S_W2,
        S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_cnt_hi;
    logic [15:0]         r_cnt;
    // one extra bit so a full-depth frame reaches N without wrapping
    logic [ADDR_W:0]     r_index;
    logic [7:0]          r_xor;
    logic [DATA_W-1:0]   r_word;

    logic                w_in_ready;
    logic                w_accept;
    logic [15:0]         w_n;
    logic                w_n_bad;
    logic                w_b0_bad;
    logic [ADDR_W:0]     w_index_inc;
    logic                w_last_word;

    assign w_in_ready  = !(r_state == S_WRITE || r_state == S_DONE || r_state == S_ERR);
    assign o_in_ready  = w_in_ready;
    assign w_accept    = i_in_valid & w_in_ready;
    assign w_n         = {r_cnt_hi, i_in_data};
    assign w_n_bad     = (w_n == 16'd0) || (32'(w_n) > DEPTH);
    assign w_b0_bad    = (i_in_data[7:3] != 5'd0);
    assign w_index_inc = r_index + (ADDR_W+1)'(1);
    assign w_last_word = (32'(w_index_inc) == 32'(r_cnt));

    assign o_imem_addr  = r_index[ADDR_W-1:0];
    assign o_imem_wdata = r_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_imem_we   = 1'b0;
        o_cpu_run   = 1'b0;
        o_done      = 1'b0;
        o_err       = 1'b0;
        case (r_state)
            S_IDLE:   if (w_accept && i_in_data == SYNC_BYTE) w_state_nxt = S_CNT_HI;
            S_CNT_HI: if (w_accept) w_state_nxt = S_CNT_LO;
            S_CNT_LO: if (w_accept) w_state_nxt = w_n_bad ? S_ERR : S_W0;
            S_W0:     if (w_accept) w_state_nxt = w_b0_bad ? S_ERR : S_W1;
            S_W1:     if (w_accept) w_state_nxt = S_W2;
            S_W2:     if (w_accept) w_state_nxt = S_WRITE;
            S_WRITE: begin
                o_imem_we   = 1'b1;
                w_state_nxt = w_last_word ? S_CHK : S_W0;
            end
            S_CHK:    if (w_accept) w_state_nxt = (i_in_data == r_xor) ? S_DONE : S_ERR;
            S_DONE: begin
                o_done    = 1'b1;
                o_cpu_run = 1'b1;
                if (i_reload) w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                o_err = 1'b1;
                if (i_reload) w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt_hi <= '0;
            r_cnt    <= '0;
            r_index  <= '0;
            r_xor    <= '0;
            r_word   <= '0;
        end else begin
            case (r_state)
                S_CNT_HI: if (w_accept) r_cnt_hi <= i_in_data;
                S_CNT_LO: if (w_accept) begin
                    r_cnt   <= w_n;
                    r_index <= '0;
                    r_xor   <= '0;
                end
                S_W0: if (w_accept && !w_b0_bad) begin
                    r_word[DATA_W-1:16] <= i_in_data[2:0];
                    r_xor               <= r_xor ^ i_in_data;
                end
                S_W1: if (w_accept) begin
                    r_word[15:8] <= i_in_data;
                    r_xor        <= r_xor ^ i_in_data;
                end
                S_W2: if (w_accept) begin
                    r_word[7:0] <= i_in_data;
                    r_xor       <= r_xor ^ i_in_data;
                end
                S_WRITE: r_index <= w_index_inc;
                default: ;
            endcase
        end
    end

endmodule
